// File: rtl/a429_rx_merge_pkg.sv
// a429_rx_merge_pkg: shared word/label/counter widths and the tag-width helper
// used by the ARINC429 receive merger.
package a429_rx_merge_pkg;
    localparam int WORD_W = 32;
    localparam int LBL_W  = 8;
    localparam int DROP_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    function automatic int calc_cw(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) w++;
        return w;
    endfunction
endpackage

// File: rtl/a429_rx_merge_chbuf.sv
// a429_rx_merge_chbuf: single-channel synchronous FIFO, head word visible
// combinationally so a pop and the egress capture happen on the same edge.
module a429_rx_merge_chbuf
    import a429_rx_merge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  flush_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  word_t din_i,
    output word_t dout_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    word_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + AW'(push_i);
        rd_d  = flush_i ? '0 : rd_q + AW'(pop_i);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/a429_rx_merge.sv
// a429_rx_merge: CH_NUM-channel ARINC429 receive merger, round-robin into one tagged FIFO.
// Optional per-channel label pass table built when A429_LABEL_FILTER_EN is defined.
module a429_rx_merge
    import a429_rx_merge_pkg::*;
#(
    parameter  int CH_NUM   = 4,
    parameter  int CH_DEPTH = 4,
    localparam int TAG_W    = calc_cw(CH_NUM - 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ena_i,
    input  logic                    flush_i,
    input  logic [CH_NUM-1:0]       ch_wr_i,
    input  logic [CH_NUM*WORD_W-1:0] ch_di_i,
    output logic [CH_NUM-1:0]       ch_fl_o,
    output logic                    of_wr_o,
    output logic [TAG_W+WORD_W-1:0] of_di_o,
    input  logic                    of_af_i,
    output logic [CH_NUM-1:0]       ovr_o,
    input  logic [CH_NUM-1:0]       ovr_clr_i,
    output logic [DROP_W-1:0]       drop_cnt_o,
    input  logic                    lf_we_i,
    input  logic [TAG_W-1:0]        lf_ch_i,
    input  logic [LBL_W-1:0]        lf_lbl_i,
    input  logic                    lf_val_i
);
    logic [CH_NUM-1:0] full, empty, pass, wr_ok, push, pop, drop;
    word_t head [CH_NUM];
    logic arb_en, gnt_vld;
    logic [TAG_W-1:0] gnt, rr_q, rr_d;
    logic of_wr_q, of_wr_d;
    logic [TAG_W+WORD_W-1:0] of_di_q, of_di_d;
    logic [CH_NUM-1:0] ovr_q, ovr_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0] drop_sum;
`ifdef A429_LABEL_FILTER_EN
    logic [(1<<LBL_W)-1:0] lf_q [CH_NUM];
    logic [(1<<LBL_W)-1:0] lf_d [CH_NUM];
    always_comb begin
        lf_d = lf_q;
        if (lf_we_i && int'(lf_ch_i) < CH_NUM) lf_d[lf_ch_i][lf_lbl_i] = lf_val_i;
        for (int k = 0; k < CH_NUM; k++) pass[k] = lf_q[k][ch_di_i[WORD_W*k +: LBL_W]];
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < CH_NUM; k++) lf_q[k] <= '1;
        end else begin
            lf_q <= lf_d;
        end
    end
`else
    logic lf_unused;
    assign lf_unused = ^{lf_we_i, lf_ch_i, lf_lbl_i, lf_val_i};
    assign pass = '1;
`endif
    // Descending scan lets the lowest offset from rr_q win the grant.
    always_comb begin
        arb_en  = ena_i && !of_af_i && !flush_i;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (arb_en && !empty[(int'(rr_q) + i) % CH_NUM]) begin
                gnt_vld = 1'b1;
                gnt     = TAG_W'((int'(rr_q) + i) % CH_NUM);
            end
        pop      = CH_NUM'(gnt_vld) << gnt;
        wr_ok    = {CH_NUM{ena_i && !flush_i}} & ch_wr_i & pass;
        push     = wr_ok & (~full | pop);
        drop     = wr_ok & full & ~pop;
        drop_sum = {1'b0, drop_q} + (DROP_W+1)'($countones(drop));
        drop_d   = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        ovr_d    = (ovr_q & ~ovr_clr_i) | drop;
        rr_d     = !gnt_vld ? rr_q : (int'(gnt) == CH_NUM - 1) ? '0 : gnt + 1'b1;
        of_wr_d  = gnt_vld;
        of_di_d  = gnt_vld ? {gnt, head[gnt]} : of_di_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rr_q    <= '0;
            of_wr_q <= 1'b0;
            of_di_q <= '0;
            ovr_q   <= '0;
            drop_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            of_wr_q <= of_wr_d;
            of_di_q <= of_di_d;
            ovr_q   <= ovr_d;
            drop_q  <= drop_d;
        end
    end
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        a429_rx_merge_chbuf #(.DEPTH(CH_DEPTH)) u_buf (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .din_i   (ch_di_i[WORD_W*k +: WORD_W]),
            .dout_o  (head[k]),
            .full_o  (full[k]),
            .empty_o (empty[k])
        );
    end
    assign ch_fl_o    = full;
    assign of_wr_o    = of_wr_q;
    assign of_di_o    = of_di_q;
    assign ovr_o      = ovr_q;
    assign drop_cnt_o = drop_q;
endmodule
